// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI INCR-burst SRAM slave with independent read and write FSMs.
// Optional AXI_SLV_DECERR_EN: out-of-range beats get DECERR instead of aliasing.
module axi_sram_slave #(
  parameter int ADDR_W = 10
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  // Holds address-channel ready low until the first edge after reset release.
  logic init_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) init_q <= 1'b0;
    else          init_q <= 1'b1;
  end

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [29:0] raddr_q, raddr_d;

  logic [29:0] rd_waddr;
  logic        rd_oor;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  // Beat data is fetched on the edge that presents it, so a same-cycle write is not seen.
  assign rd_waddr = (r_state_q == R_IDLE) ? araddr[31:2] : raddr_q;
`ifdef AXI_SLV_DECERR_EN
  assign rd_oor   = |rd_waddr[29:ADDR_W];
`else
  assign rd_oor   = 1'b0;
`endif
  assign rd_word  = rd_oor ? 32'd0 : mem[rd_waddr[ADDR_W-1:0]];
  assign rd_resp  = rd_oor ? 2'b11 : 2'b00;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && init_q) begin
          r_state_d = R_DATA;
          rid_d     = arid;
          rlen_d    = arlen;
          rcnt_d    = 4'd0;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
          rlast_d   = (arlen == 4'd0);
          raddr_d   = araddr[31:2] + 30'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            rcnt_d  = rcnt_q + 4'd1;
            rdata_d = rd_word;
            rresp_d = rd_resp;
            rlast_d = ((rcnt_q + 4'd1) == rlen_q);
            raddr_d = raddr_q + 30'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q     <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      rlen_q    <= 4'd0;
      rcnt_q    <= 4'd0;
      raddr_q   <= 30'd0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
    end
  end

  assign arready = init_q && (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [29:0] waddr_q, waddr_d;
  logic        wderr_q, wderr_d;

  logic wr_oor;
  logic cnt_done;
  logic w_mismatch;
  logic mem_we;

`ifdef AXI_SLV_DECERR_EN
  assign wr_oor = |waddr_q[29:ADDR_W];
`else
  assign wr_oor = 1'b0;
`endif
  assign cnt_done   = (wcnt_q == wlen_q);
  assign w_mismatch = (wlast != cnt_done);
  assign mem_we     = (w_state_q == W_DATA) && wvalid && !wr_oor;

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    waddr_d   = waddr_q;
    wderr_d   = wderr_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && init_q) begin
          w_state_d = W_DATA;
          bid_d     = awid;
          wlen_d    = awlen;
          wcnt_d    = 4'd0;
          waddr_d   = awaddr[31:2];
          wderr_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          wcnt_d  = wcnt_q + 4'd1;
          waddr_d = waddr_q + 30'd1;
          wderr_d = wderr_q | wr_oor;
          // Early or missing wlast both close the burst; DECERR outranks SLVERR.
          if (wlast || cnt_done) begin
            w_state_d = W_RESP;
            if (wderr_q || wr_oor) bresp_d = 2'b11;
            else if (w_mismatch)   bresp_d = 2'b10;
            else                   bresp_d = 2'b00;
          end
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      bid_q     <= 4'd0;
      bresp_q   <= 2'b00;
      wlen_q    <= 4'd0;
      wcnt_q    <= 4'd0;
      waddr_q   <= 30'd0;
      wderr_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      waddr_q   <= waddr_d;
      wderr_q   <= wderr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr_q[ADDR_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = init_q && (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  logic unused_bits;
  assign unused_bits = ^{araddr[1:0], awaddr[1:0], rd_waddr, waddr_q};

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 10, meaning: word-index width; memory holds 2**ADDR_W 32-bit words.
REQ-002 Ports SHALL be exactly these, one clock domain; clock aclk, reset aresetn asynchronous active-low:
- aclk  input  1  sole clock
- aresetn  input  1  asynchronous active-low reset
- arid  input  4  read transaction ID
- araddr  input  32  read byte address
- arlen  input  4  read beats minus one
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rid  output  4  read data ID
- rdata  output  32  read data
- rresp  output  2  read response
- rlast  output  1  last read beat
- rvalid  output  1  read data valid
- rready  input  1  read data ready
- awid  input  4  write transaction ID
- awaddr  input  32  write byte address
- awlen  input  4  write beats minus one
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  32  write data
- wstrb  input  4  write byte strobes
- wlast  input  1  last write beat
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bid  output  4  write response ID
- bresp  output  2  write response
- bvalid  output  1  write response valid
- bready  input  1  write response ready

Function
REQ-003 Burst type SHALL be INCR, size 4 bytes, regardless of master; index = addr[ADDR_W+1:2], incremented per beat, wrapping 2**ADDR_W-1 -> 0.
REQ-004 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake captures arid, index, arlen and enters R_DATA.
REQ-005 First rvalid SHALL assert exactly 1 cycle after AR handshake; rid=captured arid; rresp=2'b00; rlast=1 only on beat arlen+1.
REQ-006 While rvalid=1 and rready=0, rdata/rid/rresp/rlast SHALL hold stable; each rvalid&&rready advances one beat; last-beat acceptance returns to R_IDLE (arready=1 next cycle).
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA.
REQ-008 Each wvalid&&wready SHALL update only bytes whose wstrb bit is 1, at that clock edge.
REQ-009 Burst SHALL end on the beat where wlast=1 or beat count reaches awlen+1, whichever first; then W_RESP, bvalid=1, bid=captured awid until bready.
REQ-010 bresp SHALL be 2'b10 (SLVERR) if wlast timing mismatched awlen (early or missing on final beat), else 2'b00.
REQ-011 Read and write FSMs SHALL run concurrently; a read beat of a word written in the same cycle SHALL return the pre-write value.

Reset
REQ-012 While aresetn=0: FSMs idle; arready, awready, wready, rvalid, rlast, bvalid =0; rid, rdata, rresp, bid, bresp =0; memory contents not reset; arready/awready SHALL rise on the first edge after release; reset mid-burst aborts it with no response.

Configuration
REQ-013 With AXI_SLV_DECERR_EN defined: any beat whose byte address >= 4*2**ADDR_W SHALL give rresp/bresp 2'b11 (DECERR), rdata=0, write dropped; DECERR overrides SLVERR.
REQ-014 Without AXI_SLV_DECERR_EN: upper address bits ignored (aliasing), responses per REQ-005/REQ-010.

Verification
REQ-015 Write 0xDEADBEEF to 0x2C (awlen=0), then AR araddr=0x1FAFF02C arlen=0 -> rvalid 1 cycle later, rdata=0xDEADBEEF, rlast=1, rresp=0 (macro off).
REQ-016 awaddr=0x100 awlen=3 data 1,2,3,4 -> bresp=0; arlen=3 read -> 1,2,3,4, rlast only on beat 4.
REQ-017 Word 0x11223344, wstrb=4'b0010 wdata=0x0000AB00 -> readback 0x1122AB44.
REQ-018 rready low 3 cycles after beat 2 of 4-beat read -> beat 3 data held stable, 4 beats total, none lost.
REQ-019 araddr=0xFFC arlen=1 (ADDR_W=10) -> beats from index 1023 then 0; wlast on beat 2 of awlen=3 -> bresp=2'b10.
REQ-020 araddr=0x1000 -> macro on: rresp=2'b11, rdata=0; macro off: index-0 data, rresp=0.
